// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte-stream input, reload control, status and instruction-memory write port of the loader.
interface inst_mem_loader_if #(parameter int ADDR_W = 10);
    logic              reload;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output reload, rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, load_done, load_err, words_loaded
    );

    modport slave (
        input  reload, rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_rst, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a count-prefixed little-endian word image into instruction memory, holding the CPU in reset until done.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the payload.
module inst_mem_loader #(
    parameter int ADDR_W = 10
) (
    input logic              clk,
    input logic              rst,
    inst_mem_loader_if.slave bus
);
    typedef enum logic [2:0] {
        HDR0, HDR1, DATA,
`ifdef INST_LOADER_CHECKSUM_EN
        CHK,
`endif
        FIN, DONE, ERR
    } state_t;

    state_t          state, nxt;
    logic [7:0]      n_lo;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_inc;
    logic [1:0]      b_sel;
    logic [23:0]     word_buf;
    logic [15:0]     n_full;
    logic            bad_n;
    logic            last;
    logic            rx_st;
    logic            acc;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
    assign rx_st = state inside {HDR0, HDR1, DATA, CHK};
`else
    assign rx_st = state inside {HDR0, HDR1, DATA};
`endif

    assign bus.rx_ready     = rx_st && !bus.reload;
    assign acc              = bus.rx_valid && bus.rx_ready;
    assign n_full           = {bus.rx_data, n_lo};
    assign bad_n            = (n_full == 16'd0) || ({1'b0, n_full} > (17'd1 << ADDR_W));
    assign idx_inc          = idx + 1'b1;
    assign last             = (b_sel == 2'd3) && (idx_inc == cnt);
    assign bus.words_loaded = idx;

    always_ff @(posedge clk)
        if (rst) state <= HDR0;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            HDR0: if (acc) nxt = HDR1;
            HDR1: if (acc) nxt = bad_n ? ERR : DATA;
`ifdef INST_LOADER_CHECKSUM_EN
            DATA: if (acc && last) nxt = CHK;
            CHK:  if (acc) nxt = (bus.rx_data == csum) ? FIN : ERR;
`else
            DATA: if (acc && last) nxt = FIN;
`endif
            FIN:  nxt = DONE;
            default: ;
        endcase
        if (bus.reload) nxt = HDR0;
    end

    // Status outputs are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_rst   <= 1'b1;
            bus.load_done <= 1'b0;
            bus.load_err  <= 1'b0;
            idx           <= '0;
            cnt           <= '0;
            n_lo          <= '0;
            b_sel         <= '0;
            word_buf      <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            bus.mem_we    <= 1'b0;
            bus.cpu_rst   <= nxt != DONE;
            bus.load_done <= nxt == DONE;
            bus.load_err  <= nxt == ERR;
            if (bus.reload) idx <= '0;
            if (acc) begin
                case (state)
                    HDR0: n_lo <= bus.rx_data;
                    HDR1: begin
                        cnt   <= n_full[ADDR_W:0];
                        idx   <= '0;
                        b_sel <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                    DATA: begin
                        b_sel    <= b_sel + 1'b1;
                        word_buf <= {bus.rx_data, word_buf[23:8]};
`ifdef INST_LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.rx_data;
`endif
                        if (b_sel == 2'd3) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= idx[ADDR_W-1:0];
                            bus.mem_wdata <= {bus.rx_data, word_buf};
                            idx           <= idx_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench for inst_mem_loader; expected writes are queued as bytes are driven.
module tb_inst_mem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_loader_if #(.ADDR_W(10)) bus ();
    inst_mem_loader #(.ADDR_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] img[0:1023];
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    logic [9:0]  last_addr = '0;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]  tr_x = 8'h00;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.mem_we) begin
            wr_t e;
            we_cnt++;
            last_addr = bus.mem_addr;
            chk("wr_pending", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(bus.mem_addr), 64'(e.a));
                chk("wr_data", 64'(bus.mem_wdata), 64'(e.d));
            end
        end
    end

    task automatic put(input logic [7:0] b, input bit gaps);
        int wait_cyc = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        #1;
        while (!bus.rx_ready && wait_cyc < 200) begin
            @(negedge clk);
            #1;
            wait_cyc++;
        end
        if (!bus.rx_ready) chk("put_ready", 64'(bus.rx_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic load_image(input int n, input bit gaps);
        logic [15:0] nn = 16'(n);
`ifdef INST_LOADER_CHECKSUM_EN
        logic [7:0] cs = 8'h00;
`endif
        put(nn[7:0], 1'b0);
        put(nn[15:8], 1'b0);
        for (int k = 0; k < n; k++) begin
            sb.push_back(wr_t'{a: 10'(k), d: img[k]});
            for (int j = 0; j < 4; j++) begin
`ifdef INST_LOADER_CHECKSUM_EN
                cs ^= img[k][8*j +: 8];
`endif
                put(img[k][8*j +: 8], gaps);
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        put(cs ^ tr_x, 1'b0);
`endif
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_done(input int n);
        chk("done_early", 64'(bus.load_done), 64'd0);
        chk("cpu_rst_early", 64'(bus.cpu_rst), 64'd1);
        @(negedge clk);
        chk("load_done", 64'(bus.load_done), 64'd1);
        chk("cpu_rst_rel", 64'(bus.cpu_rst), 64'd0);
        chk("load_err_ok", 64'(bus.load_err), 64'd0);
        chk("words_loaded", 64'(bus.words_loaded), 64'(n));
        chk("addr_hold", 64'(bus.mem_addr), 64'(n - 1));
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic reload_pulse(input bit hold_valid);
        bus.reload   = 1'b1;
        bus.rx_valid = hold_valid;
        #1;
        chk("rdy_reload", 64'(bus.rx_ready), 64'd0);
        @(negedge clk);
        bus.reload   = 1'b0;
        bus.rx_valid = 1'b0;
        chk("rl_words", 64'(bus.words_loaded), 64'd0);
        chk("rl_done", 64'(bus.load_done), 64'd0);
        chk("rl_err", 64'(bus.load_err), 64'd0);
        chk("rl_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        #1;
        chk("rl_rdy_hdr0", 64'(bus.rx_ready), 64'd1);
    endtask

    task automatic bad_header(input logic [15:0] n);
        int w = we_cnt;
        reload_pulse(1'b0);
        put(n[7:0], 1'b0);
        put(n[15:8], 1'b0);
        chk("err_flag", 64'(bus.load_err), 64'd1);
        chk("err_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("err_done", 64'(bus.load_done), 64'd0);
        #1;
        chk("err_rdy", 64'(bus.rx_ready), 64'd0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("err_sticky", 64'(bus.load_err), 64'd1);
        chk("err_no_we", 64'(we_cnt), 64'(w));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        bus.reload   = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_we", 64'(bus.mem_we), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        chk("rst_done", 64'(bus.load_done), 64'd0);
        chk("rst_err", 64'(bus.load_err), 64'd0);
        chk("rst_words", 64'(bus.words_loaded), 64'd0);
        #1;
        chk("rst_rdy", 64'(bus.rx_ready), 64'd1);

        img[0] = 32'h00500013;
        img[1] = 32'h00A00093;
        load_image(2, 1'b0);
        expect_done(2);

        reload_pulse(1'b0);
        load_image(2, 1'b1);
        expect_done(2);

        bad_header(16'h0000);
        bad_header(16'h0401);

        // Abort after 6 bytes (partial word 1) and after 7 bytes with the completing byte offered alongside reload.
        for (int p = 6; p <= 7; p++) begin
            reload_pulse(1'b0);
            img[0] = 32'h11223344;
            img[1] = 32'h55667788;
            w = we_cnt;
            put(8'h02, 1'b0);
            put(8'h00, 1'b0);
            sb.push_back(wr_t'{a: 10'd0, d: img[0]});
            for (int j = 0; j < p; j++) put(img[j / 4][8*(j % 4) +: 8], 1'b0);
            bus.rx_data = img[1][8*(p - 4) +: 8];
            reload_pulse(1'b1);
            repeat (2) @(negedge clk);
            chk("abort_writes", 64'(we_cnt), 64'(w + 1));
            chk("abort_words", 64'(bus.words_loaded), 64'd0);
        end
        img[0] = 32'hCAFEF00D;
        img[1] = 32'h0BADBEEF;
        load_image(2, 1'b0);
        expect_done(2);

`ifdef INST_LOADER_CHECKSUM_EN
        reload_pulse(1'b0);
        img[0] = 32'hEFBEADDE;
        load_image(1, 1'b0);
        expect_done(1);
        reload_pulse(1'b0);
        tr_x = 8'h01;
        load_image(1, 1'b0);
        tr_x = 8'h00;
        chk("cs_err", 64'(bus.load_err), 64'd1);
        chk("cs_cpu_rst", 64'(bus.cpu_rst), 64'd1);
        @(negedge clk);
        chk("cs_cpu_rst_hold", 64'(bus.cpu_rst), 64'd1);
        chk("cs_no_done", 64'(bus.load_done), 64'd0);
`endif

        reload_pulse(1'b0);
        for (int k = 0; k < 1024; k++) img[k] = $urandom();
        load_image(1024, 1'b0);
        expect_done(1024);
        chk("last_addr", 64'(last_addr), 64'h3FF);
        w = we_cnt;
        bus.rx_data  = 8'hAA;
        bus.rx_valid = 1'b1;
        #1;
        chk("done_rdy", 64'(bus.rx_ready), 64'd0);
        repeat (3) @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("done_words", 64'(bus.words_loaded), 64'd1024);
        chk("done_hold", 64'(bus.load_done), 64'd1);
        chk("done_no_we", 64'(we_cnt), 64'(w));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
